stopwatch_ctrl: RTL and testbench

//  Control FSM for the tenths-of-a-second stopwatch counter. Debounces the four KEY

---
 rtl/stopwatch_ctrl.sv | 151 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounces KEY[3:0] into press events and runs the IDLE/RUN/PAUSE/DELAY
// state machine that emits count ticks and clear pulses for the BCD counter datapath.
module stopwatch_ctrl #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 10,
  parameter int DELAY_S    = 3,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic [3:0] KEY,
  input  logic       at_max,
  output logic       tick,
  output logic       clr,
  output logic       running,
  output logic [1:0] state,
  output logic [3:0] delay_left
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DELAY = 2'd3;

  localparam int PRE_N = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (PRE_N > 1) ? $clog2(PRE_N) : 1;
  localparam int SEC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX    = PRE_W'(PRE_N - 1);
  localparam logic [SEC_W-1:0] SEC_MAX    = SEC_W'(CLK_HZ - 1);
  localparam logic [DEB_W-1:0] DEB_MAX    = DEB_W'(DEB_CYCLES - 1);
  localparam logic [3:0]       DELAY_INIT = 4'(DELAY_S);

  logic [DEB_W-1:0] deb_cnt [4];
  logic [3:0]       key_deb;
  logic [3:0]       key_deb_d;
  logic [3:0]       press;
  logic             ev_clear;
  logic             ev_stop;
  logic             ev_start;
  logic             ev_delay;

  logic [PRE_W-1:0] pre;
  logic [PRE_W-1:0] pre_nx;
  logic [SEC_W-1:0] sec;
  logic [SEC_W-1:0] sec_nx;
  logic [1:0]       state_nx;
  logic [3:0]       left_nx;
  logic             tick_nx;
  logic             clr_nx;
  logic             pre_wrap;
  logic             sec_wrap;

  // A key's accepted level only flips after the raw level has disagreed for DEB_CYCLES cycles
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      key_deb   <= 4'hF;
      key_deb_d <= 4'hF;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      key_deb_d <= key_deb;
      for (int i = 0; i < 4; i++) begin
        if (KEY[i] != key_deb[i]) begin
          if (deb_cnt[i] == DEB_MAX) begin
            key_deb[i] <= KEY[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign press    = key_deb_d & ~key_deb;
  assign ev_clear = press[2];
  assign ev_stop  = press[1] & ~press[2];
  assign ev_start = press[0] & ~press[1] & ~press[2];
  assign ev_delay = press[3] & ~(|press[2:0]);

  assign pre_wrap = (state == S_RUN) && (pre == PRE_MAX);
  assign sec_wrap = (state == S_DELAY) && (sec == SEC_MAX);

  always_comb begin
    state_nx = state;
    pre_nx   = pre;
    sec_nx   = sec;
    left_nx  = delay_left;
    tick_nx  = 1'b0;
    clr_nx   = 1'b0;
    if (state == S_RUN) pre_nx = pre_wrap ? '0 : pre + 1'b1;
    if (state == S_DELAY) sec_nx = sec_wrap ? '0 : sec + 1'b1;

    if (ev_clear) begin
      state_nx = S_IDLE;
      pre_nx   = '0;
      sec_nx   = '0;
      left_nx  = 4'd0;
      clr_nx   = 1'b1;
    end else if (pre_wrap && at_max) begin
      // Overflow wins over any same-cycle key: show zero and stop
      state_nx = S_IDLE;
      pre_nx   = '0;
      clr_nx   = 1'b1;
    end else begin
      tick_nx = pre_wrap;
      if (sec_wrap) begin
        left_nx = delay_left - 4'd1;
        if (delay_left == 4'd1) begin
          state_nx = S_RUN;
          pre_nx   = '0;
        end
      end
      if (ev_stop && (state == S_RUN || state == S_DELAY)) begin
        state_nx = S_PAUSE;
        left_nx  = 4'd0;
      end else if (ev_start && (state == S_IDLE || state == S_PAUSE)) begin
        state_nx = S_RUN;
        if (state == S_IDLE) pre_nx = '0;
      end else if (ev_delay && (state == S_IDLE || state == S_PAUSE)) begin
        state_nx = S_DELAY;
        sec_nx   = '0;
        left_nx  = DELAY_INIT;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      running    <= 1'b0;
      pre        <= '0;
      sec        <= '0;
      delay_left <= 4'd0;
      tick       <= 1'b0;
      clr        <= 1'b0;
    end else begin
      state      <= state_nx;
      running    <= (state_nx == S_RUN);
      pre        <= pre_nx;
      sec        <= sec_nx;
      delay_left <= left_nx;
      tick       <= tick_nx;
      clr        <= clr_nx;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with scaled-down timing; expected values are hand-computed
// cycle offsets from each debounced press (press visible in state 5 cycles after the key falls).
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key;
  logic       at_max;
  logic       tick;
  logic       clr;
  logic       running;
  logic [1:0] state;
  logic [3:0] delay_left;

  int checks   = 0;
  int failures = 0;
  int tick_sum;

  stopwatch_ctrl #(
    .CLK_HZ    (100),
    .TICK_HZ   (10),
    .DELAY_S   (3),
    .DEB_CYCLES(4)
  ) dut (
    .CLOCK_50  (clk),
    .rst_n     (rst_n),
    .KEY       (key),
    .at_max    (at_max),
    .tick      (tick),
    .clr       (clr),
    .running   (running),
    .state     (state),
    .delay_left(delay_left)
  );

  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic [3:0] key_val, input logic at_max_val,
                                input logic rst_val);
    key    = key_val;
    at_max = at_max_val;
    rst_n  = rst_val;
  endtask

  // Outputs are sampled 1 time unit after the rising edge
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] got,
                              input logic [31:0] expected);
    checks++;
    if (got !== expected) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, expected);
    end
  endtask

  initial begin
    apply_stimulus(4'hF, 1'b0, 1'b0);
    wait_cycles(2);
    check_output("rst_state", 32'(state), 0);
    check_output("rst_tick", 32'(tick), 0);
    check_output("rst_clr", 32'(clr), 0);
    check_output("rst_running", 32'(running), 0);
    check_output("rst_delay_left", 32'(delay_left), 0);
    apply_stimulus(4'hF, 1'b0, 1'b1);
    wait_cycles(1);

    // Three-cycle glitch on KEY[0] is rejected
    apply_stimulus(4'b1110, 1'b0, 1'b1);
    wait_cycles(3);
    apply_stimulus(4'hF, 1'b0, 1'b1);
    wait_cycles(6);
    check_output("glitch_state", 32'(state), 0);
    check_output("glitch_tick", 32'(tick), 0);

    // Held start: RUN five cycles after the fall, ticks every 10 cycles
    apply_stimulus(4'b1110, 1'b0, 1'b1);
    wait_cycles(4);
    check_output("start_not_yet", 32'(state), 0);
    wait_cycles(1);
    check_output("start_state", 32'(state), 1);
    check_output("start_running", 32'(running), 1);
    wait_cycles(9);
    check_output("tick_early", 32'(tick), 0);
    wait_cycles(1);
    check_output("tick_first", 32'(tick), 1);
    wait_cycles(1);
    check_output("tick_single", 32'(tick), 0);
    wait_cycles(4);
    apply_stimulus(4'hF, 1'b0, 1'b1);
    wait_cycles(5);
    check_output("tick_second", 32'(tick), 1);
    check_output("held_one_event", 32'(state), 1);

    // Stop lands with the prescaler at 6
    wait_cycles(1);
    apply_stimulus(4'b1101, 1'b0, 1'b1);
    wait_cycles(4);
    check_output("stop_not_yet", 32'(state), 1);
    wait_cycles(1);
    check_output("pause_state", 32'(state), 2);
    check_output("pause_running", 32'(running), 0);
    wait_cycles(1);
    apply_stimulus(4'hF, 1'b0, 1'b1);
    tick_sum = 0;
    for (int i = 0; i < 8; i++) begin
      wait_cycles(1);
      tick_sum += int'(tick);
    end
    check_output("pause_no_ticks", 32'(tick_sum), 0);

    // Resume keeps phase: first tick 4 cycles after RUN
    apply_stimulus(4'b1110, 1'b0, 1'b1);
    wait_cycles(5);
    check_output("resume_state", 32'(state), 1);
    wait_cycles(3);
    check_output("resume_tick_early", 32'(tick), 0);
    wait_cycles(1);
    check_output("resume_tick", 32'(tick), 1);
    apply_stimulus(4'hF, 1'b0, 1'b1);
    wait_cycles(6);

    // Stop and clear together: clear wins, no PAUSE
    apply_stimulus(4'b1001, 1'b0, 1'b1);
    wait_cycles(4);
    check_output("dual_before_state", 32'(state), 1);
    check_output("dual_before_clr", 32'(clr), 0);
    wait_cycles(1);
    check_output("dual_clr", 32'(clr), 1);
    check_output("dual_tick", 32'(tick), 0);
    check_output("dual_state", 32'(state), 0);
    wait_cycles(1);
    check_output("dual_clr_pulse", 32'(clr), 0);
    check_output("dual_state_after", 32'(state), 0);
    apply_stimulus(4'hF, 1'b0, 1'b1);
    wait_cycles(6);

    // Delayed start counts 3,2,1 then runs
    apply_stimulus(4'b0111, 1'b0, 1'b1);
    wait_cycles(5);
    check_output("delay_state", 32'(state), 3);
    check_output("delay_left3", 32'(delay_left), 3);
    apply_stimulus(4'hF, 1'b0, 1'b1);
    wait_cycles(99);
    check_output("delay_left3_end", 32'(delay_left), 3);
    wait_cycles(1);
    check_output("delay_left2", 32'(delay_left), 2);
    wait_cycles(100);
    check_output("delay_left1", 32'(delay_left), 1);
    wait_cycles(99);
    check_output("delay_still", 32'(state), 3);
    wait_cycles(1);
    check_output("delay_to_run", 32'(state), 1);
    check_output("delay_left0", 32'(delay_left), 0);
    check_output("delay_running", 32'(running), 1);
    wait_cycles(9);
    check_output("delay_tick_early", 32'(tick), 0);
    wait_cycles(1);
    check_output("delay_tick", 32'(tick), 1);
    wait_cycles(1);
    apply_stimulus(4'b1011, 1'b0, 1'b1);
    wait_cycles(5);
    check_output("clear_run_clr", 32'(clr), 1);
    check_output("clear_run_state", 32'(state), 0);
    apply_stimulus(4'hF, 1'b0, 1'b1);
    wait_cycles(6);

    // Stop during DELAY aborts to PAUSE
    apply_stimulus(4'b0111, 1'b0, 1'b1);
    wait_cycles(5);
    check_output("abort_delay_state", 32'(state), 3);
    apply_stimulus(4'hF, 1'b0, 1'b1);
    wait_cycles(100);
    check_output("abort_left2", 32'(delay_left), 2);
    apply_stimulus(4'b1101, 1'b0, 1'b1);
    wait_cycles(4);
    check_output("abort_before", 32'(state), 3);
    wait_cycles(1);
    check_output("abort_state", 32'(state), 2);
    check_output("abort_left0", 32'(delay_left), 0);
    apply_stimulus(4'hF, 1'b0, 1'b1);
    wait_cycles(6);

    // Overflow: wrap at max clears and returns to IDLE
    apply_stimulus(4'b1011, 1'b0, 1'b1);
    wait_cycles(5);
    check_output("clear_pause_state", 32'(state), 0);
    apply_stimulus(4'hF, 1'b0, 1'b1);
    wait_cycles(6);
    apply_stimulus(4'b1110, 1'b0, 1'b1);
    wait_cycles(5);
    check_output("ovf_run", 32'(state), 1);
    apply_stimulus(4'hF, 1'b1, 1'b1);
    wait_cycles(9);
    check_output("ovf_before_clr", 32'(clr), 0);
    wait_cycles(1);
    check_output("ovf_clr", 32'(clr), 1);
    check_output("ovf_tick", 32'(tick), 0);
    check_output("ovf_state", 32'(state), 0);
    wait_cycles(1);
    check_output("ovf_clr_pulse", 32'(clr), 0);
    apply_stimulus(4'hF, 1'b0, 1'b1);
    wait_cycles(6);

    // Reset on the cycle a tick would appear
    apply_stimulus(4'b1110, 1'b0, 1'b1);
    wait_cycles(5);
    check_output("rst_run_state", 32'(state), 1);
    apply_stimulus(4'hF, 1'b0, 1'b1);
    wait_cycles(9);
    apply_stimulus(4'hF, 1'b0, 1'b0);
    wait_cycles(1);
    check_output("midrst_tick", 32'(tick), 0);
    check_output("midrst_clr", 32'(clr), 0);
    check_output("midrst_state", 32'(state), 0);
    check_output("midrst_running", 32'(running), 0);
    check_output("midrst_delay_left", 32'(delay_left), 0);
    apply_stimulus(4'hF, 1'b0, 1'b1);
    wait_cycles(12);
    check_output("post_rst_idle", 32'(state), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
